// File: rtl/msu_audio_streamer.sv
// MSU-1 PCM track streamer: fetches a track image sector by sector from SD,
// parses the loop point from the 8-byte header and pushes sample words to
// the audio FIFO, with stop, repeat-with-loop and FIFO-level flow control.
module msu_audio_streamer #(
  parameter int SECTOR_WORDS = 256,
  parameter int LBA_W        = 21,
  parameter int USEDW_W      = 12,
  parameter int HIGH_WATER   = 1792,
  parameter int HEADER_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        img_size,
  input  logic               trackmounting,
  input  logic               trig_play,
  input  logic               trig_stop,
  input  logic               repeat_in,
  input  logic [USEDW_W-1:0] audio_fifo_usedw,
  output logic [LBA_W-1:0]   sd_lba,
  output logic               sd_rd,
  input  logic               sd_ack,
  input  logic               sd_buff_wr,
  input  logic [15:0]        sd_buff_dout,
  output logic               pcm_wr,
  output logic [15:0]        pcm_data,
  output logic               audio_play,
  output logic               audio_end,
  output logic [31:0]        loop_index
);

  localparam int SW_LOG2 = $clog2(SECTOR_WORDS);
  localparam logic [31:0] SEC_MASK  = 32'(SECTOR_WORDS - 1);
  localparam logic [31:0] SEC_WORDS = 32'(SECTOR_WORDS);
  localparam logic [31:0] HDR_WORDS = 32'(HEADER_WORDS);
  localparam logic [31:0] MIN_IMG   = 32'(2 * HEADER_WORDS + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]  state;
  logic [31:0] word_addr;
  logic [31:0] emit_from;
  logic [31:0] total_words;
  logic        hdr_done;
  logic        rep;

  logic        abort;
  logic        emit;
  logic [33:0] loop_word_full;
  logic [31:0] loop_word;
  logic [31:0] loop_base;
  logic [31:0] sector_end;

  assign sd_lba = word_addr[SW_LOG2+LBA_W-1:SW_LOG2];

  // Loop point, emit gating and next-sector address derived from current state.
  // The loop word is formed 34 bits wide so a huge loop_index cannot wrap
  // around into a small in-range value.
  always_comb begin
    abort          = trig_stop | trackmounting;
    emit           = (word_addr >= emit_from) && (word_addr < total_words) && !abort;
    loop_word_full = 34'(HDR_WORDS) + {1'b0, loop_index, 1'b0};
    loop_word      = (loop_word_full >= {2'b00, total_words}) ? HDR_WORDS
                                                              : loop_word_full[31:0];
    loop_base      = loop_word & ~SEC_MASK;
    sector_end     = (word_addr & ~SEC_MASK) + SEC_WORDS;
  end

  // Playback state machine, word counter, header parser and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      word_addr   <= '0;
      emit_from   <= HDR_WORDS;
      total_words <= '0;
      hdr_done    <= 1'b0;
      rep         <= 1'b0;
      sd_rd       <= 1'b0;
      pcm_wr      <= 1'b0;
      pcm_data    <= '0;
      audio_play  <= 1'b0;
      audio_end   <= 1'b0;
      loop_index  <= '0;
    end else begin
      pcm_wr    <= 1'b0;
      audio_end <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig_play && !abort) begin
            if (img_size < MIN_IMG) begin
              audio_end <= 1'b1;
            end else begin
              word_addr   <= '0;
              emit_from   <= HDR_WORDS;
              hdr_done    <= 1'b0;
              total_words <= img_size >> 1;
              rep         <= repeat_in;
              audio_play  <= 1'b1;
              sd_rd       <= 1'b1;
              state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (sd_ack) sd_rd <= 1'b0;
          if (abort) begin
            audio_play <= 1'b0;
            state      <= S_DRAIN;
          end else if (sd_ack) begin
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (sd_ack && sd_buff_wr) begin
            word_addr <= word_addr + 32'd1;
            pcm_wr    <= emit;
            pcm_data  <= sd_buff_dout;
            if (!hdr_done) begin
              if (word_addr == 32'd2) loop_index[15:0] <= sd_buff_dout;
              if (word_addr == 32'd3) begin
                loop_index[31:16] <= sd_buff_dout;
                hdr_done          <= 1'b1;
              end
            end
          end
          if (abort) begin
            audio_play <= 1'b0;
            state      <= S_DRAIN;
          end else if (!sd_ack) begin
            if ((word_addr & SEC_MASK) != '0) word_addr <= sector_end;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            audio_play <= 1'b0;
            state      <= S_IDLE;
          end else if (32'(audio_fifo_usedw) < 32'(HIGH_WATER)) begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (abort) begin
            audio_play <= 1'b0;
            state      <= S_IDLE;
          end else if (word_addr < total_words) begin
            sd_rd <= 1'b1;
            state <= S_REQ;
          end else if (rep) begin
            word_addr <= loop_base;
            emit_from <= loop_word;
            sd_rd     <= 1'b1;
            state     <= S_REQ;
          end else begin
            audio_play <= 1'b0;
            audio_end  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (sd_rd) begin
            if (sd_ack) sd_rd <= 1'b0;
          end else if (!sd_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (trackmounting) begin
        loop_index <= '0;
        hdr_done   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msu_audio_streamer.sv
// Self-checking bench for msu_audio_streamer: an SD slot model serves sector
// reads from a synthetic image, a scoreboard queue holds expected PCM words
// and expected sector addresses.
module tb_msu_audio_streamer;

  localparam int SW = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] img_size = '0;
  logic        trackmounting = 1'b0;
  logic        trig_play = 1'b0;
  logic        trig_stop = 1'b0;
  logic        repeat_in = 1'b0;
  logic [11:0] audio_fifo_usedw = '0;
  logic [20:0] sd_lba;
  logic        sd_rd;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_dout;
  logic        pcm_wr;
  logic [15:0] pcm_data;
  logic        audio_play;
  logic        audio_end;
  logic [31:0] loop_index;

  msu_audio_streamer #(
    .SECTOR_WORDS(256), .LBA_W(21), .USEDW_W(12), .HIGH_WATER(1792), .HEADER_WORDS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .img_size(img_size), .trackmounting(trackmounting),
    .trig_play(trig_play), .trig_stop(trig_stop), .repeat_in(repeat_in),
    .audio_fifo_usedw(audio_fifo_usedw), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_dout(sd_buff_dout),
    .pcm_wr(pcm_wr), .pcm_data(pcm_data), .audio_play(audio_play),
    .audio_end(audio_end), .loop_index(loop_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int pcm_cnt = 0;
  int end_cnt = 0;
  int rd_cnt = 0;
  int unsigned cur_word = 0;
  logic model_busy = 1'b0;
  logic [31:0] cur_loop = '0;
  logic [15:0] exp_q[$];
  int unsigned lba_q[$];

  typedef struct {
    logic [31:0] img;
    logic [31:0] loopi;
    int exp_pcm;
    int exp_lbas;
    int exp_end;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] img_word(input int unsigned a);
    if (a == 2) return cur_loop[15:0];
    if (a == 3) return cur_loop[31:16];
    return 16'hC000 ^ a[15:0];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_words(input int unsigned lo, input int unsigned hi);
    for (int unsigned a = lo; a <= hi; a++) exp_q.push_back(img_word(a));
  endtask

  task automatic push_lbas(input int unsigned lo, input int unsigned hi);
    for (int unsigned l = lo; l <= hi; l++) lba_q.push_back(l);
  endtask

  task automatic start(input logic [31:0] img, input logic rep);
    img_size  = img;
    repeat_in = rep;
    trig_play = 1'b1;
    tick();
    trig_play = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && lba_q.size() == 0 && !model_busy &&
             sd_rd == 1'b0 && audio_play == 1'b0)) begin
      tick();
      if (++n > budget) begin timeout(name); return; end
    end
  endtask

  task automatic wait_model_free(input string name, input int budget);
    int n = 0;
    while (!(lba_q.size() == 0 && !model_busy && !sd_ack)) begin
      tick();
      if (++n > budget) begin timeout(name); return; end
    end
  endtask

  task automatic wait_rd(input string name, input int budget);
    int n = 0;
    while (sd_rd !== 1'b1) begin
      tick();
      if (++n > budget) begin timeout(name); return; end
    end
  endtask

  // Repeat playback: one full pass, one loop pass, then stop on the next loop request.
  task automatic loop_test(input string name, input logic [31:0] img, input logic [31:0] loopi,
                           input int unsigned loop_first, input int unsigned loop_lba);
    int unsigned last = img / 2 - 1;
    int unsigned nsec = (img / 2 + SW - 1) / SW;
    int e0 = end_cnt;
    int n = 0;
    cur_loop = loopi;
    push_lbas(0, nsec - 1);
    push_words(4, last);
    push_lbas(loop_lba, nsec - 1);
    push_words(loop_first, last);
    lba_q.push_back(loop_lba);
    start(img, 1'b1);
    while (!(exp_q.size() == 0 && lba_q.size() == 1)) begin
      tick();
      if (++n > 6000) begin timeout({name, "_pass"}); break; end
    end
    wait_rd({name, "_rerd"}, 40);
    check32({name, "_loop_lba"}, 32'(sd_lba), loop_lba);
    trig_stop = 1'b1;
    tick();
    trig_stop = 1'b0;
    check32({name, "_play_off"}, 32'(audio_play), 32'd0);
    wait_model_free({name, "_drain"}, 600);
    repeat (10) tick();
    check32({name, "_sd_rd_idle"}, 32'(sd_rd), 32'd0);
    check32({name, "_no_end"}, 32'(end_cnt - e0), 32'd0);
    check32({name, "_loop_index"}, loop_index, loopi);
  endtask

  // Scoreboard monitor: every PCM write pops one expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (audio_end === 1'b1) end_cnt++;
      if (pcm_wr === 1'b1) begin
        pcm_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL pcm_unexpected: pcm_wr with data 0x%0h, none expected", pcm_data);
        end else begin
          check32("pcm_data", 32'(pcm_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // SD slot model: acknowledges each read and streams one sector with gaps.
  initial begin
    int unsigned rq;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    sd_buff_dout = '0;
    forever begin
      @(negedge clk);
      if (reset_n && sd_rd === 1'b1 && !sd_ack) begin
        rq = 32'(sd_lba);
        rd_cnt++;
        model_busy = 1'b1;
        if (lba_q.size() == 0) begin
          checks++;
          $display("FAIL sd_read_unexpected: lba %0d requested, none expected", rq);
        end else begin
          check32("sd_lba", rq, lba_q.pop_front());
        end
        repeat (3) @(negedge clk);
        sd_ack = 1'b1;
        for (int i = 0; i < SW; i++) begin
          if (i % 50 == 49) begin
            @(negedge clk);
            sd_buff_wr = 1'b0;
          end
          @(negedge clk);
          cur_word = rq * SW + i;
          sd_buff_wr = 1'b1;
          sd_buff_dout = img_word(cur_word);
        end
        @(negedge clk);
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d)", passes, checks);
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int e0, p0, r0, n;
    vecs[0] = '{img: 32'd1040, loopi: 32'h0000_0010, exp_pcm: 516, exp_lbas: 3, exp_end: 1};
    vecs[1] = '{img: 32'd6,    loopi: 32'h0,         exp_pcm: 0,   exp_lbas: 0, exp_end: 1};
    vecs[2] = '{img: 32'd9,    loopi: 32'h0,         exp_pcm: 0,   exp_lbas: 0, exp_end: 1};
    vecs[3] = '{img: 32'd10,   loopi: 32'h1234_5678, exp_pcm: 1,   exp_lbas: 1, exp_end: 1};
    vecs[4] = '{img: 32'd11,   loopi: 32'hABCD_0001, exp_pcm: 1,   exp_lbas: 1, exp_end: 1};
    vecs[5] = '{img: 32'd1024, loopi: 32'h0000_0007, exp_pcm: 508, exp_lbas: 2, exp_end: 1};
    vecs[6] = '{img: 32'd1027, loopi: 32'h0000_0003, exp_pcm: 509, exp_lbas: 3, exp_end: 1};

    // Reset state.
    repeat (3) tick();
    check32("reset_outputs",
            {sd_rd, pcm_wr, audio_play, audio_end, 11'd0, sd_lba},
            32'd0);
    check32("reset_pcm_loop", {pcm_data, loop_index[15:0]} | loop_index, 32'd0);
    reset_n = 1'b1;
    tick();

    // Non-repeat playbacks, FIFO empty.
    foreach (vecs[k]) begin
      cur_loop = vecs[k].loopi;
      e0 = end_cnt; p0 = pcm_cnt; r0 = rd_cnt;
      if (vecs[k].exp_pcm > 0) push_words(4, 4 + vecs[k].exp_pcm - 1);
      if (vecs[k].exp_lbas > 0) push_lbas(0, vecs[k].exp_lbas - 1);
      start(vecs[k].img, 1'b0);
      wait_idle($sformatf("vec%0d_done", k), 4000);
      repeat (10) tick();
      check32($sformatf("vec%0d_pcm_count", k), 32'(pcm_cnt - p0), 32'(vecs[k].exp_pcm));
      check32($sformatf("vec%0d_end_count", k), 32'(end_cnt - e0), 32'(vecs[k].exp_end));
      check32($sformatf("vec%0d_reads", k), 32'(rd_cnt - r0), 32'(vecs[k].exp_lbas));
      check32($sformatf("vec%0d_sd_rd", k), 32'(sd_rd), 32'd0);
      if (vecs[k].exp_lbas > 0)
        check32($sformatf("vec%0d_loop_index", k), loop_index, vecs[k].loopi);
    end

    // Repeat with non-aligned loop point, and with an out-of-range loop point.
    loop_test("loop130", 32'd2048, 32'd130, 264, 1);
    loop_test("loopmax", 32'd1024, 32'hFFFF_FFFF, 4, 0);

    // FIFO flow control.
    cur_loop = 32'd9;
    e0 = end_cnt;
    audio_fifo_usedw = 12'd1792;
    push_lbas(0, 0);
    push_words(4, 1023);
    start(32'd2048, 1'b0);
    wait_model_free("flow_first", 600);
    repeat (40) tick();
    check32("flow_hold_sd_rd", 32'(sd_rd), 32'd0);
    push_lbas(1, 3);
    audio_fifo_usedw = 12'd1791;
    repeat (2) tick();
    check32("flow_release_sd_rd", 32'(sd_rd), 32'd1);
    wait_idle("flow_done", 3000);
    audio_fifo_usedw = '0;
    repeat (5) tick();
    check32("flow_end", 32'(end_cnt - e0), 32'd1);

    // Stop in the middle of a sector transfer, at word 100.
    cur_loop = 32'd2;
    e0 = end_cnt;
    push_lbas(0, 0);
    push_words(4, 99);
    start(32'd2048, 1'b0);
    n = 0;
    while (!(sd_buff_wr && cur_word == 100)) begin
      tick();
      if (++n > 600) begin timeout("stop_word100"); break; end
    end
    trig_stop = 1'b1;
    tick();
    trig_stop = 1'b0;
    check32("stop_play_off", 32'(audio_play), 32'd0);
    repeat (5) tick();
    check32("stop_ack_still_high", 32'(sd_ack), 32'd1);
    trig_play = 1'b1;   // must be ignored while draining
    tick();
    trig_play = 1'b0;
    wait_model_free("stop_drain", 600);
    repeat (20) tick();
    check32("stop_sd_rd", 32'(sd_rd), 32'd0);
    check32("stop_play_idle", 32'(audio_play), 32'd0);
    check32("stop_no_end", 32'(end_cnt - e0), 32'd0);
    check32("stop_words_left", 32'(exp_q.size()), 32'd0);

    // trackmounting clears the parsed loop index.
    trackmounting = 1'b1;
    tick();
    trackmounting = 1'b0;
    check32("mount_loop_index", loop_index, 32'd0);

    // Asynchronous reset in the middle of a transfer.
    cur_loop = 32'd5;
    p0 = pcm_cnt;
    push_lbas(0, 3);
    push_words(4, 1023);
    start(32'd2048, 1'b0);
    n = 0;
    while (pcm_cnt - p0 < 20) begin
      tick();
      if (++n > 600) begin timeout("rst_progress"); break; end
    end
    check32("rst_pre_play", 32'(audio_play), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check32("rst_async_ctrl", {sd_rd, pcm_wr, audio_play, audio_end, 11'd0, sd_lba}, 32'd0);
    check32("rst_async_data", {16'd0, pcm_data} | loop_index, 32'd0);
    exp_q.delete();
    lba_q.delete();
    wait_model_free("rst_model", 600);
    tick();
    reset_n = 1'b1;
    tick();

    // Same-cycle play and stop in IDLE: stop wins.
    e0 = end_cnt;
    img_size = 32'd2048;
    trig_play = 1'b1;
    trig_stop = 1'b1;
    tick();
    trig_play = 1'b0;
    trig_stop = 1'b0;
    repeat (20) tick();
    check32("playstop_play", 32'(audio_play), 32'd0);
    check32("playstop_sd_rd", 32'(sd_rd), 32'd0);
    check32("playstop_end", 32'(end_cnt - e0), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
